// File: rtl/alu_pkg.sv
// Shared types for the ALU execution path: op codes (also used by the ALU control
// generator), execution FSM states and the control-code width.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLT  = 4'd5,
        SLL  = 4'd6,
        SRL  = 4'd7,
        SRA  = 4'd8,
        SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter: moves the loaded operand one bit per cycle until the count runs out.
// value presents the next-step result so the final step can be registered by the caller.
module alu_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   operand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   value
);

    logic [WIDTH-1:0]   val;
    logic [WIDTH-1:0]   step;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_q;
    logic               arith_q;

    // dir=0 shifts left; dir=1 shifts right, filling with the sign bit when arith
    always_comb begin
        if (!dir_q) step = {val[WIDTH-2:0], 1'b0};
        else        step = {arith_q & val[WIDTH-1], val[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val     <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            val     <= operand;
            cnt     <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (cnt != '0) begin
            val <= step;
            cnt <= cnt - SHAMT_W'(1);
        end
    end

    assign busy  = (cnt != '0);
    assign done  = (cnt == SHAMT_W'(1));
    assign value = step;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready in, valid/ready out, 1-cycle logic/arith ops.
// Shifts are iterative unless ALU_FAST_SHIFT_EN selects a combinational barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                illegal
);

    alu_state_e       state;
    logic             accept;
    logic             start_shift;
    logic             op_illegal;
    logic [WIDTH-1:0] exec_res;

    function automatic logic [WIDTH-1:0] exec_calc(input logic [ALU_OP_W-1:0] c,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (c)
            ADD:  r = a + b;
            SUB:  r = a - b;
            AND:  r = a & b;
            OR:   r = a | b;
            XOR:  r = a ^ b;
            SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU: r = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_FAST_SHIFT_EN
            SLL:  r = a << b[SHAMT_W-1:0];
            SRL:  r = a >> b[SHAMT_W-1:0];
            SRA:  r = $signed(a) >>> b[SHAMT_W-1:0];
`else
            // only reached with a zero shift amount; nonzero amounts go to the shifter
            SLL, SRL, SRA: r = a;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign op_illegal = (alu_ctrl > SLTU);
    assign exec_res   = exec_calc(alu_ctrl, op_a, op_b);

`ifdef ALU_FAST_SHIFT_EN
    assign start_shift = 1'b0;
`else
    logic             sh_busy;
    logic             sh_done;
    logic [WIDTH-1:0] sh_value;

    assign start_shift = (alu_ctrl == SLL || alu_ctrl == SRL || alu_ctrl == SRA) &&
                         (op_b[SHAMT_W-1:0] != '0);

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && start_shift),
        .dir     (alu_ctrl != SLL),
        .arith   (alu_ctrl == SRA),
        .shamt   (op_b[SHAMT_W-1:0]),
        .operand (op_a),
        .busy    (sh_busy),
        .done    (sh_done),
        .value   (sh_value)
    );
`endif

    // The EXEC step is evaluated on the accept edge itself so single-cycle ops
    // land in DONE one cycle after acceptance; DONE re-accepts without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                state     <= SHIFT;
                out_valid <= 1'b0;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= exec_res;
                zero      <= (exec_res == '0);
                illegal   <= op_illegal;
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
`ifndef ALU_FAST_SHIFT_EN
        else if (state == SHIFT && sh_busy && sh_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= sh_value;
            zero      <= (sh_value == '0);
            illegal   <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake corner sequences and
// random traffic, all checked through an expected-result queue.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        il;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        il;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_sent   = 0;
    int   n_out    = 0;
    logic rnd_ready = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << s;
            4'd7: return a >> s;
            4'd8: return $signed(a) >>> s;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        return (c >= 4'd6 && c <= 4'd8) ? int'(b[4:0]) : 0;
`endif
    endfunction

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic z, input logic il, output int waited);
        exp_t e;
        waited   = 0;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 200);
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles", in_ready, waited);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        e.res = res;
        e.z   = z;
        e.il  = il;
        e.lat = lat_of(c, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        n_sent++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic send_rnd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int w;
        logic [31:0] r;
        r = ref_res(c, a, b);
        send(c, a, b, r, r == 32'd0, c > 4'd9, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Output side: pops the scoreboard on every handshake and checks hold stability.
    exp_t        mon_e;
    logic        prev_hold  = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [31:0] prev_res   = '0;
    int          vstart     = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hold) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_result", result, prev_res);
            end
            if (out_valid && (!prev_valid || prev_hs)) vstart = cyc;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: result=%h with no request outstanding", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk1("zero", zero, mon_e.z);
                    chk1("illegal", illegal, mon_e.il);
                    chk("latency", 32'(vstart - mon_e.acc), 32'(mon_e.lat));
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_res   = result;
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    initial begin
        int w;
        int vcount;
        logic [3:0] c;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;

        vt[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vt[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[2]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        vt[3]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vt[4]  = '{4'd8,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[5]  = '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0};
        vt[6]  = '{4'd6,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0};
        vt[7]  = '{4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1};
        vt[8]  = '{4'd0,  32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0, 1'b0};
        vt[9]  = '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
        vt[10] = '{4'd3,  32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00, 1'b0, 1'b0};
        vt[11] = '{4'd4,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
        vt[12] = '{4'd6,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0};
        vt[13] = '{4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vt[14] = '{4'd6,  32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 1'b0, 1'b0};
        vt[15] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'd0);
        chk1("reset_zero", zero, 1'b0);
        chk1("reset_illegal", illegal, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            send(vt[i].c, vt[i].a, vt[i].b, vt[i].res, vt[i].z, vt[i].il, w);
        drain();

        // Consumer stalls for 4 cycles, then accepts while a new request arrives.
        out_ready = 1'b0;
        send(4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk1("stall_out_valid", out_valid, 1'b1);
            chk("stall_result", result, 32'd7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'd4, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FF0, 1'b0, 1'b0, w);
        chk("reaccept_wait_cycles", 32'(w), 32'd1);
        drain();

        // Reset while an sll by 20 is still shifting.
        send(4'd6, 32'h0000_0001, 32'd20, 32'h0010_0000, 1'b0, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
        chk1("mid_shift_out_valid", out_valid, 1'b0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b0;
        n_sent -= sb.size();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("post_reset_out_valid", out_valid, 1'b0);
        chk1("post_reset_in_ready", in_ready, 1'b1);
        chk("post_reset_result", result, 32'd0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("stale_output_cycles", 32'(vcount), 32'd0);
        @(posedge clk); #1;

        // Random traffic with a randomly stalling consumer.
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            c = 4'($urandom_range(0, 10));
            if (c == 4'd10) c = 4'($urandom_range(10, 15));
            send_rnd(c, rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("outstanding_results", 32'(sb.size()), 32'd0);
        chk("result_count", 32'(n_out), 32'(n_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
